// File: rtl/uart_pkg.sv
// Shared definitions for the UART command-packet controller:
// FSM state encoding, error codes and the default packet start marker.
package uart_pkg;

  // Controller states, 3-bit encoding
  typedef enum logic [2:0] {
    ST_IDLE     = 3'd0,
    ST_GET_ADDR = 3'd1,
    ST_GET_LEN  = 3'd2,
    ST_GET_DATA = 3'd3,
    ST_GET_CHK  = 3'd4,
    ST_DRAIN    = 3'd5
  } state_t;

  // Error codes reported on o_Err_Code alongside o_Pkt_Err
  localparam logic [1:0] ERR_NONE = 2'b00;
  localparam logic [1:0] ERR_LEN  = 2'b01;
  localparam logic [1:0] ERR_CHK  = 2'b10;
  localparam logic [1:0] ERR_TMO  = 2'b11;

  // Default packet start marker
  localparam logic [7:0] SYNC_BYTE_DEF = 8'hA5;

  // A length byte is acceptable when it is 1..max_len
  function automatic logic len_ok(input logic [7:0] len, input int max_len);
    return (len != 8'd0) && (int'(len) <= max_len);
  endfunction

endpackage

// File: rtl/uart_cmd_buf.sv
// Payload store for one command packet: DEPTH x 8 register array with a
// synchronous write port (fed while receiving) and a combinational read port
// (indexed by the drain pointer).
module uart_cmd_buf #(
  parameter int DEPTH = 16,
  parameter int AW    = 4
) (
  input  logic          i_Clock,
  input  logic          i_We,
  input  logic [AW-1:0] i_Wr_Idx,
  input  logic [7:0]    i_Wr_Byte,
  input  logic [AW-1:0] i_Rd_Idx,
  output logic [7:0]    o_Rd_Byte
);

  logic [7:0] r_mem [DEPTH];

  // Capture one payload byte per write strobe; out-of-range indices are ignored
  always_ff @(posedge i_Clock) begin
    if (i_We && (int'(i_Wr_Idx) < DEPTH)) begin
      r_mem[i_Wr_Idx] <= i_Wr_Byte;
    end
  end

  // The drain pointer may step one past the last entry; return 0 there
  assign o_Rd_Byte = (int'(i_Rd_Idx) < DEPTH) ? r_mem[i_Rd_Idx] : 8'h00;

endmodule

// File: rtl/uart_rx_cmd_ctrl.sv
// Command-packet controller downstream of the UART receiver. Frames received
// bytes into SYNC/ADDR/LEN/payload/CHK packets, buffers the payload, and only
// after a good checksum replays it as register writes on a valid/ready port.
module uart_rx_cmd_ctrl
  import uart_pkg::*;
#(
  parameter int         CLKS_PER_BIT = 217,
  parameter int         TIMEOUT_CLKS = 20 * CLKS_PER_BIT,
  parameter int         MAX_LEN      = 16,
  parameter logic [7:0] SYNC_BYTE    = SYNC_BYTE_DEF
) (
  input  logic       i_Clock,
  input  logic       i_Reset,
  input  logic       i_RX_DV,
  input  logic [7:0] i_RX_Byte,
  output logic       o_Wr_Valid,
  input  logic       i_Wr_Ready,
  output logic [7:0] o_Wr_Addr,
  output logic [7:0] o_Wr_Data,
  output logic       o_Busy,
  output logic       o_Pkt_Done,
  output logic       o_Pkt_Err,
  output logic [1:0] o_Err_Code,
  output logic       o_Overrun
);

  localparam int AW = (MAX_LEN > 1) ? $clog2(MAX_LEN) : 1;
  localparam int TW = $clog2(TIMEOUT_CLKS + 1);
  localparam logic [TW-1:0] TMO_LAST = TW'(TIMEOUT_CLKS - 1);

  state_t        r_state;
  logic [7:0]    r_addr;
  logic [7:0]    r_len;
  logic [7:0]    r_idx;       // payload write index, reused as drain pointer
  logic [7:0]    r_chk;       // running mod-256 checksum
  logic [TW-1:0] r_tmo;       // idle clocks since the last byte in a packet
  logic          r_wr_valid;
  logic [7:0]    r_wr_addr;
  logic [7:0]    r_wr_data;
  logic          r_pkt_done;
  logic          r_pkt_err;
  logic [1:0]    r_err_code;
  logic          r_overrun;

  logic          w_buf_we;
  logic [AW-1:0] w_rd_idx;
  logic [7:0]    w_rd_byte;

  // Payload bytes go into the buffer at the current write index
  assign w_buf_we = (r_state == ST_GET_DATA) && i_RX_DV;

  // Read entry 0 while waiting for the checksum, otherwise the next drain entry,
  // so the output register can be reloaded on the same edge as a transfer
  assign w_rd_idx = (r_state == ST_DRAIN) ? (r_idx[AW-1:0] + AW'(1)) : '0;

  uart_cmd_buf #(
    .DEPTH (MAX_LEN),
    .AW    (AW)
  ) u_buf (
    .i_Clock   (i_Clock),
    .i_We      (w_buf_we),
    .i_Wr_Idx  (r_idx[AW-1:0]),
    .i_Wr_Byte (i_RX_Byte),
    .i_Rd_Idx  (w_rd_idx),
    .o_Rd_Byte (w_rd_byte)
  );

  // Packet framing FSM with checksum, timeout counter and registered outputs
  always_ff @(posedge i_Clock) begin
    if (i_Reset) begin
      r_state    <= ST_IDLE;
      r_addr     <= 8'h00;
      r_len      <= 8'h00;
      r_idx      <= 8'h00;
      r_chk      <= 8'h00;
      r_tmo      <= '0;
      r_wr_valid <= 1'b0;
      r_wr_addr  <= 8'h00;
      r_wr_data  <= 8'h00;
      r_pkt_done <= 1'b0;
      r_pkt_err  <= 1'b0;
      r_err_code <= ERR_NONE;
      r_overrun  <= 1'b0;
    end else begin
      r_pkt_done <= 1'b0;
      r_pkt_err  <= 1'b0;
      r_overrun  <= 1'b0;

      case (r_state)
        ST_IDLE: begin
          r_tmo <= '0;
          if (i_RX_DV && (i_RX_Byte == SYNC_BYTE)) begin
            r_state <= ST_GET_ADDR;
          end
        end

        ST_GET_ADDR, ST_GET_LEN, ST_GET_DATA, ST_GET_CHK: begin
          // A byte always beats a coincident timeout expiry
          if (i_RX_DV) begin
            r_tmo <= '0;
            case (r_state)
              ST_GET_ADDR: begin
                r_addr  <= i_RX_Byte;
                r_chk   <= i_RX_Byte;
                r_state <= ST_GET_LEN;
              end
              ST_GET_LEN: begin
                if (!len_ok(i_RX_Byte, MAX_LEN)) begin
                  r_pkt_err  <= 1'b1;
                  r_err_code <= ERR_LEN;
                  r_state    <= ST_IDLE;
                end else begin
                  r_len   <= i_RX_Byte;
                  r_chk   <= r_chk + i_RX_Byte;
                  r_idx   <= 8'h00;
                  r_state <= ST_GET_DATA;
                end
              end
              ST_GET_DATA: begin
                r_chk <= r_chk + i_RX_Byte;
                r_idx <= r_idx + 8'd1;
                if (r_idx == (r_len - 8'd1)) begin
                  r_state <= ST_GET_CHK;
                end
              end
              ST_GET_CHK: begin
                if (i_RX_Byte == r_chk) begin
                  r_idx      <= 8'h00;
                  r_wr_valid <= 1'b1;
                  r_wr_addr  <= r_addr;
                  r_wr_data  <= w_rd_byte;
                  r_state    <= ST_DRAIN;
                end else begin
                  r_pkt_err  <= 1'b1;
                  r_err_code <= ERR_CHK;
                  r_state    <= ST_IDLE;
                end
              end
              default: r_state <= ST_IDLE;
            endcase
          end else if (r_tmo == TMO_LAST) begin
            r_tmo      <= '0;
            r_pkt_err  <= 1'b1;
            r_err_code <= ERR_TMO;
            r_state    <= ST_IDLE;
          end else begin
            r_tmo <= r_tmo + TW'(1);
          end
        end

        ST_DRAIN: begin
          r_tmo <= '0;
          // Bytes arriving now cannot be framed; drop and flag them
          if (i_RX_DV) begin
            r_overrun <= 1'b1;
          end
          if (r_wr_valid && i_Wr_Ready) begin
            if (r_idx == (r_len - 8'd1)) begin
              r_wr_valid <= 1'b0;
              r_pkt_done <= 1'b1;
              r_state    <= ST_IDLE;
            end else begin
              r_idx     <= r_idx + 8'd1;
              r_wr_addr <= r_wr_addr + 8'd1;
              r_wr_data <= w_rd_byte;
            end
          end
        end

        default: r_state <= ST_IDLE;
      endcase
    end
  end

  assign o_Wr_Valid = r_wr_valid;
  assign o_Wr_Addr  = r_wr_addr;
  assign o_Wr_Data  = r_wr_data;
  assign o_Busy     = (r_state != ST_IDLE);
  assign o_Pkt_Done = r_pkt_done;
  assign o_Pkt_Err  = r_pkt_err;
  assign o_Err_Code = r_err_code;
  assign o_Overrun  = r_overrun;

endmodule

// File: tb/tb_uart_rx_cmd_ctrl.sv
// Directed bench for uart_rx_cmd_ctrl: good packets, backpressure, checksum,
// length and timeout errors, address wrap, overrun and mid-packet reset.
module tb_uart_rx_cmd_ctrl;

  localparam int TMO = 20 * 217;

  logic       i_Clock;
  logic       i_Reset;
  logic       i_RX_DV;
  logic [7:0] i_RX_Byte;
  logic       o_Wr_Valid;
  logic       i_Wr_Ready;
  logic [7:0] o_Wr_Addr;
  logic [7:0] o_Wr_Data;
  logic       o_Busy;
  logic       o_Pkt_Done;
  logic       o_Pkt_Err;
  logic [1:0] o_Err_Code;
  logic       o_Overrun;

  int n_vec;
  int n_err;

  uart_rx_cmd_ctrl dut (
    .i_Clock    (i_Clock),
    .i_Reset    (i_Reset),
    .i_RX_DV    (i_RX_DV),
    .i_RX_Byte  (i_RX_Byte),
    .o_Wr_Valid (o_Wr_Valid),
    .i_Wr_Ready (i_Wr_Ready),
    .o_Wr_Addr  (o_Wr_Addr),
    .o_Wr_Data  (o_Wr_Data),
    .o_Busy     (o_Busy),
    .o_Pkt_Done (o_Pkt_Done),
    .o_Pkt_Err  (o_Pkt_Err),
    .o_Err_Code (o_Err_Code),
    .o_Overrun  (o_Overrun)
  );

  initial i_Clock = 1'b0;
  always #5 i_Clock = ~i_Clock;

  task automatic tick();
    @(posedge i_Clock);
    #1;
  endtask

  // Strobe one byte for exactly one clock edge
  task automatic rx(input logic [7:0] b);
    i_RX_DV   = 1'b1;
    i_RX_Byte = b;
    @(posedge i_Clock);
    #1;
    i_RX_DV   = 1'b0;
    i_RX_Byte = 8'h00;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_vec++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // {valid, addr, data}
  task automatic chk_wr(input string tag, input logic v, input logic [7:0] a, input logic [7:0] d);
    chk(tag, {15'd0, o_Wr_Valid, o_Wr_Addr, o_Wr_Data}, {15'd0, v, a, d});
  endtask

  // {done, err, code}
  task automatic chk_flags(input string tag, input logic dn, input logic er, input logic [1:0] cd);
    chk(tag, {28'd0, o_Pkt_Done, o_Pkt_Err, o_Err_Code}, {28'd0, dn, er, cd});
  endtask

  function automatic logic [22:0] all_outs();
    return {o_Wr_Valid, o_Wr_Addr, o_Wr_Data, o_Busy, o_Pkt_Done,
            o_Pkt_Err, o_Err_Code, o_Overrun};
  endfunction

  initial begin
    n_vec      = 0;
    n_err      = 0;
    i_Reset    = 1'b1;
    i_RX_DV    = 1'b0;
    i_RX_Byte  = 8'h00;
    i_Wr_Ready = 1'b1;

    // Reset state
    tick();
    tick();
    chk("reset_outs", {9'd0, all_outs()}, 32'd0);
    i_Reset = 1'b0;
    tick();
    chk("post_reset_outs", {9'd0, all_outs()}, 32'd0);

    // Good packet A5 10 02 11 22 45, ready high
    rx(8'hA5);
    chk("good_busy", {31'd0, o_Busy}, 32'd1);
    rx(8'h10);
    rx(8'h02);
    rx(8'h11);
    rx(8'h22);
    chk_wr("good_prechk", 1'b0, 8'h00, 8'h00);
    rx(8'h45);
    chk_wr("good_wr0", 1'b1, 8'h10, 8'h11);
    tick();
    chk_wr("good_wr1", 1'b1, 8'h11, 8'h22);
    tick();
    chk("good_valid_drop", {31'd0, o_Wr_Valid}, 32'd0);
    chk_flags("good_done", 1'b1, 1'b0, 2'b00);
    tick();
    chk_flags("good_done_pulse", 1'b0, 1'b0, 2'b00);
    chk("good_idle", {31'd0, o_Busy}, 32'd0);

    // Backpressure: ready low for three cycles
    i_Wr_Ready = 1'b0;
    rx(8'hA5); rx(8'h10); rx(8'h02); rx(8'h11); rx(8'h22); rx(8'h45);
    chk_wr("bp_wr0", 1'b1, 8'h10, 8'h11);
    for (int i = 0; i < 3; i++) begin
      tick();
      chk_wr($sformatf("bp_hold%0d", i), 1'b1, 8'h10, 8'h11);
    end
    i_Wr_Ready = 1'b1;
    tick();
    chk_wr("bp_wr1", 1'b1, 8'h11, 8'h22);
    tick();
    chk("bp_valid_drop", {31'd0, o_Wr_Valid}, 32'd0);
    chk_flags("bp_done", 1'b1, 1'b0, 2'b00);

    // Bad checksum
    rx(8'hA5); rx(8'h10); rx(8'h02); rx(8'h11); rx(8'h22); rx(8'h00);
    chk("chk_no_valid", {31'd0, o_Wr_Valid}, 32'd0);
    chk_flags("chk_err", 1'b0, 1'b1, 2'b10);
    tick();
    chk_flags("chk_err_hold_code", 1'b0, 1'b0, 2'b10);
    chk("chk_idle", {31'd0, o_Busy}, 32'd0);

    // Bad length: 0, then 17
    rx(8'hA5); rx(8'h10); rx(8'h00);
    chk_flags("len0_err", 1'b0, 1'b1, 2'b01);
    chk("len0_idle", {31'd0, o_Busy}, 32'd0);
    rx(8'hA5); rx(8'h10); rx(8'h11);
    chk_flags("len17_err", 1'b0, 1'b1, 2'b01);
    chk("len17_idle", {31'd0, o_Busy}, 32'd0);

    // Maximum length 16: addr 20, payload 0..15, chk 20+10+78 = A8
    rx(8'hA5); rx(8'h20); rx(8'h10);
    for (int i = 0; i < 16; i++) rx(8'(i));
    rx(8'hA8);
    for (int i = 0; i < 16; i++) begin
      chk_wr($sformatf("len16_wr%0d", i), 1'b1, 8'(8'h20 + i), 8'(i));
      tick();
    end
    chk("len16_valid_drop", {31'd0, o_Wr_Valid}, 32'd0);
    chk_flags("len16_done", 1'b1, 1'b0, 2'b01);

    // Timeout after A5 10: error exactly TMO clocks after the last strobe
    rx(8'hA5); rx(8'h10);
    for (int i = 0; i < TMO - 1; i++) tick();
    chk_flags("tmo_not_yet", 1'b0, 1'b0, 2'b01);
    chk("tmo_still_busy", {31'd0, o_Busy}, 32'd1);
    tick();
    chk_flags("tmo_err", 1'b0, 1'b1, 2'b11);
    chk("tmo_idle", {31'd0, o_Busy}, 32'd0);

    // Good packet after timeout: A5 30 01 5A 8B
    rx(8'hA5); rx(8'h30); rx(8'h01); rx(8'h5A); rx(8'h8B);
    chk_wr("after_tmo_wr0", 1'b1, 8'h30, 8'h5A);
    tick();
    chk_flags("after_tmo_done", 1'b1, 1'b0, 2'b11);

    // Sync byte as payload: A5 50 02 A5 A5 9C
    rx(8'hA5); rx(8'h50); rx(8'h02); rx(8'hA5); rx(8'hA5); rx(8'h9C);
    chk_wr("sync_data_wr0", 1'b1, 8'h50, 8'hA5);
    tick();
    chk_wr("sync_data_wr1", 1'b1, 8'h51, 8'hA5);
    tick();
    chk_flags("sync_data_done", 1'b1, 1'b0, 2'b11);

    // Address wrap with an overrun byte during the drain
    rx(8'hA5); rx(8'hFE); rx(8'h03); rx(8'h01); rx(8'h02); rx(8'h03); rx(8'h07);
    chk_wr("wrap_wr0", 1'b1, 8'hFE, 8'h01);
    chk("wrap_no_overrun", {31'd0, o_Overrun}, 32'd0);
    rx(8'h77);
    chk("wrap_overrun", {31'd0, o_Overrun}, 32'd1);
    chk_wr("wrap_wr1", 1'b1, 8'hFF, 8'h02);
    tick();
    chk("wrap_overrun_pulse", {31'd0, o_Overrun}, 32'd0);
    chk_wr("wrap_wr2", 1'b1, 8'h00, 8'h03);
    tick();
    chk("wrap_valid_drop", {31'd0, o_Wr_Valid}, 32'd0);
    chk_flags("wrap_done", 1'b1, 1'b0, 2'b11);

    // Reset mid-payload
    rx(8'hA5); rx(8'h40); rx(8'h03); rx(8'h01);
    chk("rst_busy_before", {31'd0, o_Busy}, 32'd1);
    i_Reset = 1'b1;
    tick();
    i_Reset = 1'b0;
    chk("rst_mid_outs", {9'd0, all_outs()}, 32'd0);
    for (int i = 0; i < 3; i++) begin
      tick();
      chk($sformatf("rst_quiet%0d", i), {9'd0, all_outs()}, 32'd0);
    end
    rx(8'h02); rx(8'h03);
    chk("rst_leftover_ignored", {9'd0, all_outs()}, 32'd0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule

// File: doc/uart_rx_cmd_ctrl.md
# uart_rx_cmd_ctrl

Command-packet controller downstream of the UART receiver. It consumes the receiver's one-cycle byte strobes, frames them into packets (sync, address, length, payload, checksum), and buffers the payload. It releases the payload as register-write transactions over a valid/ready handshake only after the checksum passes. It sits between the UART receiver and the control/status register bank.

## Interface
- CLKS_PER_BIT, 217: clocks per UART bit; must match the receiver.
- TIMEOUT_CLKS, 20*CLKS_PER_BIT: maximum idle clocks between bytes inside a packet.
- MAX_LEN, 16: maximum payload bytes; range 1..255.
- SYNC_BYTE, 8'hA5: packet start marker.
- i_Clock  in  1  sole clock, rising edge.
- i_Reset  in  1  synchronous reset, active-high. One clock; reset is synchronous and active-high.
- i_RX_DV  in  1  byte-valid strobe from receiver, one cycle wide.
- i_RX_Byte  in  8  received byte, valid when i_RX_DV=1.
- o_Wr_Valid  out  1  write transaction valid.
- i_Wr_Ready  in  1  register bank accepts the transaction.
- o_Wr_Addr  out  8  write address.
- o_Wr_Data  out  8  write data.
- o_Busy  out  1  high in any state other than IDLE.
- o_Pkt_Done  out  1  one-cycle pulse: packet fully written.
- o_Pkt_Err  out  1  one-cycle pulse: packet discarded.
- o_Err_Code  out  2  01 bad length, 10 checksum mismatch, 11 timeout; valid with o_Pkt_Err, holds last value otherwise.
- o_Overrun  out  1  one-cycle pulse: byte dropped during DRAIN.

## Operation
- States: IDLE, GET_ADDR, GET_LEN, GET_DATA, GET_CHK, DRAIN.
- IDLE:
  - A byte equal to SYNC_BYTE moves to GET_ADDR.
  - Other bytes are ignored silently.
- GET_ADDR: latch the byte as ADDR, then GET_LEN.
- GET_LEN:
  - Length 0 or >MAX_LEN: pulse o_Pkt_Err with code 01, go to IDLE.
  - Otherwise latch LEN, clear the index, go to GET_DATA.
- GET_DATA:
  - Write byte to buffer[index], increment index.
  - After LEN bytes, go to GET_CHK.
  - SYNC_BYTE values inside a packet are ordinary data; there is no resync.
- GET_CHK:
  - Checksum = (ADDR + LEN + sum of payload) mod 256, held in an 8-bit accumulator.
  - Equal to the received byte: go to DRAIN.
  - Otherwise: o_Pkt_Err with code 10, go to IDLE.
- DRAIN:
  - Present entry i with o_Wr_Addr = (ADDR + i) mod 256 and o_Wr_Data = buffer[i].
  - A transfer occurs on a clock edge where o_Wr_Valid and i_Wr_Ready are both high.
  - After transfer LEN-1: o_Pkt_Done pulses, go to IDLE.
- Timeout:
  - In GET_ADDR through GET_CHK, a counter clears on each i_RX_DV.
  - If the count reaches TIMEOUT_CLKS-1 with no byte: o_Pkt_Err with code 11, go to IDLE.
  - The counter is inactive in IDLE and DRAIN.
- Overrun: i_RX_DV in DRAIN drops the byte and pulses o_Overrun. The drain is unaffected.
- Simultaneous timeout expiry and i_RX_DV: the byte wins and the counter clears.

## Timing
- Reset values of all outputs are 0: o_Wr_Valid, o_Wr_Addr, o_Wr_Data, o_Busy, o_Pkt_Done, o_Pkt_Err, o_Err_Code, o_Overrun. State resets to IDLE; counters and checksum clear.
- Reset mid-packet or mid-drain discards everything, with no Done or Err pulse. Buffer contents are don't-care.
- A byte strobed at edge N is reflected in state and outputs after edge N.
- Checksum pass at edge N gives o_Wr_Valid=1 with entry 0 in the cycle after N.
- o_Wr_Addr and o_Wr_Data are stable while o_Wr_Valid=1 and i_Wr_Ready=0.
- With i_Wr_Ready held high, one transfer occurs per cycle. o_Wr_Valid drops and o_Pkt_Done=1 in the cycle after the last transfer edge.
- Error pulses appear in the cycle after the offending edge (byte edge or timeout edge).
- The address wraps mod 256; for example ADDR=FE with LEN=3 writes FE, FF, 00.

## Structure
- Shared package uart_pkg holds:
  - the state encoding (3-bit);
  - error code constants ERR_LEN=01, ERR_CHK=10, ERR_TMO=11;
  - the SYNC_BYTE default.
- Sub-module uart_cmd_buf is the payload store: MAX_LEN×8 register array with a synchronous write port and a combinational read port indexed by the drain pointer.
- Controller FSM, checksum accumulator, and timeout counter live in uart_rx_cmd_ctrl.

## Test plan
- Good packet: A5 10 02 11 22 with CHK=45, i_Wr_Ready=1 -> writes (10,11) and (11,22) on consecutive cycles, then one o_Pkt_Done pulse.
- Backpressure: same packet with i_Wr_Ready low for 3 cycles -> o_Wr_Valid held with (10,11) stable; both writes complete after Ready rises.
- Bad checksum: A5 10 02 11 22 00 -> no o_Wr_Valid; o_Pkt_Err with o_Err_Code=10.
- Bad length: A5 10 00, then A5 10 11 with MAX_LEN=16 -> two o_Pkt_Err pulses, code 01; FSM back in IDLE.
- Timeout: A5 10, then silence for TIMEOUT_CLKS -> o_Pkt_Err code 11 exactly TIMEOUT_CLKS after the last strobe. A following good packet is accepted.
- Wrap, overrun, and reset:
  - A5 FE 03 01 02 03 with CHK=07 -> addresses FE, FF, 00.
  - A byte strobed during DRAIN -> o_Overrun pulses and the writes are unaffected.
  - i_Reset mid-payload -> all outputs 0 and no pulses.
